// File: rtl/sys_defs.sv
// Shared machine-wide definitions for the multiplier issue path: function encodings,
// physical register tag type and default multiplier depth.
package sys_defs;

  typedef enum logic [1:0] {
    M_MUL    = 2'd0,
    M_MULH   = 2'd1,
    M_MULHSU = 2'd2,
    M_MULHU  = 2'd3
  } mult_func_e;

  localparam int unsigned PRN_W = 6;
  typedef logic [PRN_W-1:0] prn_t;

  localparam int unsigned MULT_DEPTH_DFLT = 4;

endpackage

// File: rtl/mult_ctrl_if.sv
// Bundle between the multiply controller, its reservation-station requesters, the multiplier
// pipeline and the CDB. The master side is the controller.
interface mult_ctrl_if
  import sys_defs::*;
#(
  parameter int unsigned NUM_REQ = 2
) ();

  localparam int unsigned SelW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic       [NUM_REQ-1:0] req_valid;
  mult_func_e [NUM_REQ-1:0] req_func;
  prn_t       [NUM_REQ-1:0] req_tag;
  logic       [NUM_REQ-1:0] req_gnt;
  logic                     mult_start;
  logic       [SelW-1:0]    mult_sel;
  mult_func_e               mult_func;
  logic                     mult_done;
  logic                     mult_stall;
  logic                     mult_flush;
  logic                     cdb_req;
  prn_t                     cdb_tag;
  logic                     cdb_gnt;
  logic                     squash;
  logic                     busy;

  modport master (
    input  req_valid, req_func, req_tag, mult_done, cdb_gnt, squash,
    output req_gnt, mult_start, mult_sel, mult_func, mult_stall, mult_flush,
           cdb_req, cdb_tag, busy
  );

  modport slave (
    output req_valid, req_func, req_tag, mult_done, cdb_gnt, squash,
    input  req_gnt, mult_start, mult_sel, mult_func, mult_stall, mult_flush,
           cdb_req, cdb_tag, busy
  );

endinterface

// File: rtl/mult_tag_fifo.sv
// In-order FIFO of destination tags for multiplies currently inside the multiplier.
// Pointers wrap modulo Depth, so Depth need not be a power of two.
module mult_tag_fifo
  import sys_defs::*;
#(
  parameter int unsigned Depth = MULT_DEPTH_DFLT,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  prn_t            push_tag,
  input  logic            pop,
  output prn_t            head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  prn_t            mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (32'(ptr) == Depth - 1) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full    = (32'(count_q) == Depth);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag;
  end

endmodule

// File: rtl/mult_ctrl.sv
// Issue/complete controller for a shared pipelined multiplier: round-robin grant among
// requesters, in-order tag tracking and a single CDB hold register with backpressure.
module mult_ctrl
  import sys_defs::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned MULT_DEPTH = MULT_DEPTH_DFLT
) (
  input logic       clock,
  input logic       reset,
  mult_ctrl_if.master bus
);

  localparam int unsigned SelW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(MULT_DEPTH + 1);

  logic [SelW-1:0] rr_ptr_q, rr_ptr_d, win_idx;
  logic            win_found, can_issue, grant, done_take;
  logic            hold_valid_q, hold_valid_d;
  prn_t            cdb_tag_q, cdb_tag_d, fifo_head;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] inflight_count;
  int unsigned     idx;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = SelW'(idx);
      end
    end
  end

  assign can_issue = ~bus.squash & ~bus.mult_stall & ~fifo_full;
  assign grant     = win_found & can_issue;

  always_comb begin
    bus.req_gnt   = '0;
    bus.mult_sel  = '0;
    bus.mult_func = M_MUL;
    if (grant) begin
      bus.req_gnt[win_idx] = 1'b1;
      bus.mult_sel         = win_idx;
      bus.mult_func        = bus.req_func[win_idx];
    end
  end

  assign bus.mult_start = grant;
  assign bus.mult_stall = hold_valid_q & ~bus.cdb_gnt;
  assign bus.mult_flush = bus.squash;
  assign bus.cdb_req    = hold_valid_q;
  assign bus.cdb_tag    = cdb_tag_q;
  assign bus.busy       = hold_valid_q | (inflight_count != '0);

  // Done is dropped while stalled, squashed, or with nothing outstanding.
  assign done_take = bus.mult_done & ~bus.mult_stall & ~fifo_empty & ~bus.squash;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    hold_valid_d = hold_valid_q;
    cdb_tag_d    = cdb_tag_q;
    if (grant) begin
      rr_ptr_d = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + SelW'(1);
    end
    if (bus.squash) begin
      hold_valid_d = 1'b0;
    end else if (done_take) begin
      hold_valid_d = 1'b1;
      cdb_tag_d    = fifo_head;
    end else if (bus.cdb_gnt && hold_valid_q) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr_q     <= '0;
      hold_valid_q <= 1'b0;
      cdb_tag_q    <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      hold_valid_q <= hold_valid_d;
      cdb_tag_q    <= cdb_tag_d;
    end
  end

  mult_tag_fifo #(
    .Depth(MULT_DEPTH)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (bus.squash),
    .push     (grant),
    .push_tag (bus.req_tag[win_idx]),
    .pop      (done_take),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (inflight_count)
  );

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl: a fairness sequence followed by a table of cycle-by-cycle
// vectors covering single op, backpressure, full, squash and mid-stream reset.
module tb_mult_ctrl;
  import sys_defs::*;

  typedef struct {
    logic       rst;
    logic [1:0] rv;
    logic [5:0] t0, t1;
    logic [1:0] f0, f1;
    logic       done, cg, sq, chk;
    logic [1:0] gnt;
    logic       sel;
    logic [1:0] func;
    logic       stall, flush, creq;
    logic [5:0] ctag;
    logic       busy;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   applied = 0;
  int   errors  = 0;
  int   cur     = 0;

  always #5 clock = ~clock;

  mult_ctrl_if #(.NUM_REQ(2)) bus ();

  mult_ctrl #(
    .NUM_REQ    (2),
    .MULT_DEPTH (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic vec_t mk(int rst, int rv, int t0, int t1, int f0, int f1, int done,
                              int cg, int sq, int chk, int gnt, int sel, int func,
                              int stall, int flush, int creq, int ctag, int busy);
    vec_t v;
    v.rst = 1'(rst);    v.rv = 2'(rv);      v.t0 = 6'(t0);      v.t1 = 6'(t1);
    v.f0 = 2'(f0);      v.f1 = 2'(f1);      v.done = 1'(done);  v.cg = 1'(cg);
    v.sq = 1'(sq);      v.chk = 1'(chk);    v.gnt = 2'(gnt);    v.sel = 1'(sel);
    v.func = 2'(func);  v.stall = 1'(stall); v.flush = 1'(flush); v.creq = 1'(creq);
    v.ctag = 6'(ctag);  v.busy = 1'(busy);
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", name, cur, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset          = v.rst;
    bus.req_valid  = v.rv;
    bus.req_tag[0] = v.t0;
    bus.req_tag[1] = v.t1;
    bus.req_func[0] = mult_func_e'(v.f0);
    bus.req_func[1] = mult_func_e'(v.f1);
    bus.mult_done  = v.done;
    bus.cdb_gnt    = v.cg;
    bus.squash     = v.sq;
  endtask

  task automatic check(input vec_t v);
    applied++;
    cmp("req_gnt",    32'(bus.req_gnt),    32'(v.gnt));
    cmp("mult_start", 32'(bus.mult_start), 32'(v.gnt != 2'b00));
    cmp("mult_sel",   32'(bus.mult_sel),   32'(v.sel));
    cmp("mult_func",  32'(bus.mult_func),  32'(v.func));
    cmp("mult_stall", 32'(bus.mult_stall), 32'(v.stall));
    cmp("mult_flush", 32'(bus.mult_flush), 32'(v.flush));
    cmp("cdb_req",    32'(bus.cdb_req),    32'(v.creq));
    cmp("busy",       32'(bus.busy),       32'(v.busy));
    if (v.creq) cmp("cdb_tag", 32'(bus.cdb_tag), 32'(v.ctag));
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic step(input vec_t v);
    drive(v);
    #1;
    if (v.chk) check(v);
    @(posedge clock);
    #1;
    cur++;
  endtask

  vec_t tbl[$];

  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clock);
    #1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    // Both requesters ready, a done every cycle: grants must alternate.
    for (int k = 0; k < 6; k++) begin
      step(mk(1, 3, 3, 4, 0, 3, 1, 1, 0, 1, (k % 2 == 0) ? 1 : 2, k % 2,
              (k % 2 == 0) ? 0 : 3, 0, 0, (k >= 2) ? 1 : 0, (k % 2 == 0) ? 3 : 4,
              (k >= 1) ? 1 : 0));
    end
    step(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 3, 1));
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 4, 1));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    //            rst rv t0 t1 f0 f1 dn cg sq chk gnt sel fn stl fl crq tag bsy
    // single op
    tbl.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 1,  7,  0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1,  7, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1,  7, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0));
    // backpressure (rr_ptr = 1 here)
    tbl.push_back(mk(1, 1, 10,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 2,  0, 11, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 1, 12,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 10, 1));
    tbl.push_back(mk(1, 1, 12,  0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 1, 10, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 10, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 11, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0));
    // full
    tbl.push_back(mk(1, 1, 20,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 2,  0, 21, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 1, 22,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 2,  0, 23, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 3, 24, 26, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 1, 24,  0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 1, 24,  0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 20, 1));
    tbl.push_back(mk(1, 1, 25,  0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 21, 1));
    tbl.push_back(mk(1, 1, 25,  0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    // squash with 3 in flight and a held result
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 3, 27, 28, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 22, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3, 29, 30, 0, 2, 0, 0, 0, 1, 2, 1, 2, 0, 0, 0,  0, 0));
    // reset mid-stream with 2 in flight
    tbl.push_back(mk(1, 1, 31,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3, 40, 41, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 40, 1));
    tbl.push_back(mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0));

    foreach (tbl[i]) step(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
